byte_combiner: RTL and testbench
================================

Name: byte_combiner

Overview:
- Inverse of the word-to-byte splitter: collects a serial byte stream and reassembles it into a 32-bit word.
- The first byte received lands in bits [31:24]; the fourth lands in [7:0]. This matches the splitter's O1..O4 lane order, so splitter -> serializer -> byte_combiner is lossless.
- Sits on the receive side of the byte link, feeding word-wide consumers (register file, memory write path) through a valid/ready handshake.
- Supports short final words via in_last, and abort of a partial word via clear.

Parameters:
- BYTE_W, 8, width of one input byte lane.
- LANES, 4, bytes per output word; word width = BYTE_W*LANES = 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion (0) clears all state immediately; deassertion is synchronous to clk.
- clear  input  1  synchronous abort of the partially assembled word.
- in_valid  input  1  in_byte is valid this cycle.
- in_ready  output  1  combiner accepts a byte this cycle.
- in_byte  input  8  incoming byte.
- in_last  input  1  qualifies in_byte as the final byte of a word; forces early completion.
- out_valid  output  1  out_word/out_count hold a completed word.
- out_ready  input  1  consumer takes the word this cycle.
- out_word  output  32  assembled word; unfilled low lanes are zero.
- out_count  output  3  number of valid bytes in out_word, 1..4.

Behaviour:
Reset (reset=0, async):
- cnt=0, asm=0, out_valid=0, out_word=0, out_count=0.
- in_ready reads 1 once reset is released.

Handshakes:
- Byte accept = in_valid & in_ready.
- Word transfer = out_valid & out_ready.
- in_ready = !out_valid | out_ready. It is purely combinational and does not depend on in_valid or in_last.

Lane placement:
- The byte accepted at position cnt=k is written to asm[31-8k -: 8].
- cnt is a 2-bit counter, 0..3.

Non-completing accept (cnt<3 and in_last=0):
- Write the lane; cnt <= cnt+1.
- out_* unchanged.

Completing accept (cnt==3, or in_last=1):
- Next cycle: out_word = asm with the new byte merged, lanes beyond position cnt forced to 0.
- Next cycle: out_count = cnt+1, out_valid = 1.
- Same edge: cnt <= 0, asm <= 0.
- Latency: word visible 1 cycle after the accepting edge.

Output register:
- Holds its value while out_valid & !out_ready. No byte is accepted in that state, since in_ready=0.
- Transfer with no completing accept in the same cycle: out_valid <= 0. out_word and out_count keep stale values.
- Transfer plus completing accept in the same cycle: the new word is loaded and out_valid stays 1. This sustains 1 byte/cycle and a word every 4 cycles with no bubble.

clear (synchronous):
- cnt <= 0, asm <= 0.
- A byte accepted in the same cycle is consumed and discarded, and does not complete a word.
- The output register and out_valid are unaffected; a pending word survives clear.

Boundary conditions:
- in_last at cnt=0 gives a 1-byte word: out_word = {b,24'h0}, out_count = 1.
- in_last at cnt=3 is identical to normal completion (out_count = 4).
- in_valid=0 with in_last=1 is ignored.
- Reset mid-word: the partial word and any pending output are lost.
- No overflow: cnt never exceeds 3.
- Inputs are don't-care when in_valid=0.

Decomposition:
- Shared constants header: BYTE_W=8, LANES=4, WORD_W=32, CNT_W=2.
- The same header is used by the splitter-side serializer so lane order is defined in one place.
- Single module; no sub-module is warranted. Lane-write decode and output register are each under ~20 lines.
- Expected size is about 120-150 lines of RTL.

Test Plan:
1. Reset mid-word: send 0x11,0x22, assert reset=0 for 1 cycle -> out_valid=0, out_count=0, in_ready=1. Then a full word 0xA1,0xB2,0xC3,0xD4 -> out_word=0xA1B2C3D4, out_count=4.
2. Streaming with out_ready held at 1: 8 back-to-back bytes 0x01..0x08 -> in_ready never drops. Words 0x01020304 then 0x05060708, each valid for exactly 1 cycle, 4 cycles apart.
3. Short words: 0xAA with in_last -> 0xAA000000, count 1. Then 0x12,0x34,0x56 with in_last on 0x56 -> 0x12345600, count 3.
4. Backpressure: complete 0xDEADBEEF with out_ready=0 for 5 cycles -> in_ready=0 and the word is held stable. Raise out_ready with the next byte 0x99 already presented -> transfer occurs and 0x99 is accepted the same cycle.
5. Clear: 0x11,0x22, then clear concurrent with byte 0x33, then 0x44,0x55,0x66,0x77 -> out_word=0x44556677, count 4. A word pending at the time of clear is still delivered unchanged.
6. Async reset with no clock edge: assert reset while out_valid=1 -> all outputs go to 0 before the next clk edge.

Source files
------------

// File: rtl/byte_combiner_pkg.sv
// Lane geometry shared by the byte combiner and the splitter-side serializer,
// so the byte order on the link is defined in exactly one place.
package byte_combiner_pkg;

    localparam int BYTE_W  = 8;
    localparam int LANES   = 4;
    localparam int WORD_W  = BYTE_W * LANES;
    localparam int CNT_W   = 2;
    localparam int COUNT_W = 3;

    // Position 0 is the first byte on the wire and occupies the most significant lane.
    function automatic int lane_msb(input int pos);
        return WORD_W - 1 - BYTE_W * pos;
    endfunction

endpackage

// File: rtl/byte_combiner.sv
// Reassembles a serial byte stream into 32-bit words, first byte in [31:24].
// Short words are closed with in_last; clear drops a partially built word.
module byte_combiner
    import byte_combiner_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BYTE_W-1:0]   in_byte,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_word,
    output logic [COUNT_W-1:0]  out_count
);

    logic [CNT_W-1:0]   cnt_reg;
    logic [WORD_W-1:0]  asm_reg;
    logic               out_valid_reg;
    logic [WORD_W-1:0]  out_word_reg;
    logic [COUNT_W-1:0] out_count_reg;

    logic [WORD_W-1:0]  merged_word;
    logic               byte_accept;
    logic               word_done;
    logic               word_xfer;

    assign in_ready    = !out_valid_reg || out_ready;
    assign byte_accept = in_valid && in_ready;
    assign word_done   = byte_accept && !clear && ((cnt_reg == CNT_W'(LANES - 1)) || in_last);
    assign word_xfer   = out_valid_reg && out_ready;

    // Current byte drops into lane cnt; lanes after it are zeroed so short words are clean.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int HI = lane_msb(gi);
            always_comb begin
                if (cnt_reg == CNT_W'(gi)) begin
                    merged_word[HI -: BYTE_W] = in_byte;
                end else if (CNT_W'(gi) > cnt_reg) begin
                    merged_word[HI -: BYTE_W] = '0;
                end else begin
                    merged_word[HI -: BYTE_W] = asm_reg[HI -: BYTE_W];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
            asm_reg <= '0;
        end else if (clear || word_done) begin
            cnt_reg <= '0;
            asm_reg <= '0;
        end else if (byte_accept) begin
            cnt_reg <= cnt_reg + 1'b1;
            asm_reg <= merged_word;
        end
    end

    // A completing accept reloads the register even during a transfer, giving no bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_word_reg  <= '0;
            out_count_reg <= '0;
        end else if (word_done) begin
            out_valid_reg <= 1'b1;
            out_word_reg  <= merged_word;
            out_count_reg <= {1'b0, cnt_reg} + 1'b1;
        end else if (word_xfer) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_word  = out_word_reg;
    assign out_count = out_count_reg;

endmodule

// File: tb/tb_byte_combiner.sv
// Directed and random stimulus for byte_combiner against a queue-based word model.
module tb_byte_combiner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_byte = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic [2:0]  out_count;

    int checks = 0;
    int failures = 0;
    int words_seen = 0;

    // Reference model: bytes of the word in progress plus the output holding slot.
    logic [7:0]  part_q[$];
    logic        m_valid;
    logic [31:0] m_word;
    logic [2:0]  m_count;

    always #5 clk = ~clk;

    byte_combiner dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] build_word();
        logic [31:0] w = 32'h0;
        for (int i = 0; i < part_q.size(); i++)
            w = w + (32'(part_q[i]) << (8 * (3 - i)));
        return w;
    endfunction

    task automatic model_reset();
        part_q.delete();
        m_valid = 1'b0;
        m_word  = 32'h0;
        m_count = 3'd0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, m_valid});
        chk({tag, ".out_word"},  out_word, m_word);
        chk({tag, ".out_count"}, {29'h0, out_count}, {29'h0, m_count});
    endtask

    // One clock cycle: drive, check in_ready, advance the model, check the registered outputs.
    task automatic cycle(input logic iv, input logic [7:0] ib, input logic il,
                         input logic cl, input logic ordy, input string tag);
        logic rdy, acc, xfer, done;
        in_valid = iv; in_byte = ib; in_last = il; clear = cl; out_ready = ordy;
        #1;
        rdy  = !m_valid || ordy;
        chk({tag, ".in_ready"}, {31'h0, in_ready}, {31'h0, rdy});
        acc  = iv && rdy;
        xfer = m_valid && ordy;
        done = 1'b0;
        if (xfer) begin
            words_seen++;
            $display("word %0d: %h count=%0d", words_seen, m_word, m_count);
        end
        if (acc && cl) begin
            part_q.delete();
        end else if (acc) begin
            part_q.push_back(ib);
            if (part_q.size() == 4 || il) begin
                m_word  = build_word();
                m_count = 3'(part_q.size());
                m_valid = 1'b1;
                part_q.delete();
                done = 1'b1;
            end
        end else if (cl) begin
            part_q.delete();
        end
        if (!done && xfer) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic il, input string tag);
        cycle(1'b1, b, il, 1'b0, 1'b1, tag);
    endtask

    task automatic idle(input logic ordy, input string tag);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, ordy, tag);
    endtask

    initial begin
        // Power-on reset
        model_reset();
        #2;
        chk("por.out_valid", {31'h0, out_valid}, 32'h0);
        chk("por.out_word", out_word, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("por.in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);

        // 1. Reset mid-word, then a full word
        send(8'h11, 1'b0, "t1.b0");
        send(8'h22, 1'b0, "t1.b1");
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("t1.rst");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t1.rst.in_ready", {31'h0, in_ready}, 32'h1);
        send(8'hA1, 1'b0, "t1.w0");
        send(8'hB2, 1'b0, "t1.w1");
        send(8'hC3, 1'b0, "t1.w2");
        send(8'hD4, 1'b0, "t1.w3");
        chk("t1.word", out_word, 32'hA1B2C3D4);
        chk("t1.count", {29'h0, out_count}, 32'd4);
        idle(1'b1, "t1.drain");

        // 2. Streaming with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b0, "t2.stream");
            if (i == 4) chk("t2.word0", out_word, 32'h01020304);
            if (i == 8) chk("t2.word1", out_word, 32'h05060708);
        end
        idle(1'b1, "t2.drain");
        chk("t2.valid_one_cycle", {31'h0, out_valid}, 32'h0);

        // 3. Short words
        send(8'hAA, 1'b1, "t3.one");
        chk("t3.one.word", out_word, 32'hAA000000);
        chk("t3.one.count", {29'h0, out_count}, 32'd1);
        send(8'h12, 1'b0, "t3.b0");
        send(8'h34, 1'b0, "t3.b1");
        send(8'h56, 1'b1, "t3.b2");
        chk("t3.three.word", out_word, 32'h12345600);
        chk("t3.three.count", {29'h0, out_count}, 32'd3);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "t3.last_no_valid");

        // 4. Backpressure
        cycle(1'b1, 8'hDE, 1'b0, 1'b0, 1'b0, "t4.b0");
        cycle(1'b1, 8'hAD, 1'b0, 1'b0, 1'b0, "t4.b1");
        cycle(1'b1, 8'hBE, 1'b0, 1'b0, 1'b0, "t4.b2");
        cycle(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, "t4.b3");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, "t4.hold");
            chk("t4.hold.word", out_word, 32'hDEADBEEF);
        end
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, "t4.release");
        chk("t4.release.valid", {31'h0, out_valid}, 32'h0);
        cycle(1'b1, 8'h88, 1'b1, 1'b0, 1'b1, "t4.after");
        chk("t4.after.word", out_word, 32'h99880000);

        // 5. Clear, with a word pending across it
        send(8'h01, 1'b1, "t5.pending");
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, "t5.b0");
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "t5.clr_pend");
        chk("t5.pending_kept", out_word, 32'h01000000);
        send(8'h11, 1'b0, "t5.b0b");
        send(8'h22, 1'b0, "t5.b1");
        cycle(1'b1, 8'h33, 1'b1, 1'b1, 1'b1, "t5.clr");
        send(8'h44, 1'b0, "t5.c0");
        send(8'h55, 1'b0, "t5.c1");
        send(8'h66, 1'b0, "t5.c2");
        send(8'h77, 1'b0, "t5.c3");
        chk("t5.word", out_word, 32'h44556677);
        chk("t5.count", {29'h0, out_count}, 32'd4);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(3) != 0), 8'($urandom), ($urandom_range(5) == 0),
                  ($urandom_range(19) == 0), ($urandom_range(9) < 7), "rnd");
        end

        // 6. Async reset with out_valid=1 and no clock edge
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, "t6.load");
        chk("t6.loaded", {31'h0, out_valid}, 32'h1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("t6.async");
        @(negedge clk);
        reset = 1'b1;
        idle(1'b1, "t6.post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
